// File: rtl/uart_pkg.sv
// Shared FSM states, register map and STATUS bit positions for the MMIO UART transmitter.
// This package contains declarations only. It has no latency of its own.
// It has no flow control of its own. The DIV sanitising helper lives here.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Register word index, taken from addr[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;
  localparam int STAT_PAR   = 4;

  // A zero divisor would never end a bit, so it is stored as 1.
  function automatic logic [15:0] div_sanitize(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous TX byte FIFO with show-ahead output (pop_dat valid whenever !empty).
// Latency: a push is visible on pop_dat one cycle later. A pop frees its entry on the same edge.
// Backpressure: none internally. The caller must qualify push with full and pop with empty.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_vld,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_vld) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_dat;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop_vld) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/uart_tx_mmio.sv
// MMIO UART transmitter: bus writes queue bytes that are sent as 8N1 frames, or 8E1 with UART_PARITY_EN.
// Latency: tx falls 1 cycle after a TXDATA write to an idle, empty block. A frame lasts 10*DIV or 11*DIV cycles.
// Backpressure: none on the bus. A write to a full FIFO without a same-cycle pop is dropped and sets sticky overflow.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq_empty
);

`ifdef UART_PARITY_EN
  localparam logic PARITY_PRESENT = 1'b1;
`else
  localparam logic PARITY_PRESENT = 1'b0;
`endif

  uart_state_e state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [15:0] bit_div_q, bit_div_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        ovf_q, ovf_d;
  logic        tx_q, tx_d;
`ifdef UART_PARITY_EN
  logic        par_q, par_d;
`endif

  logic        fifo_full, fifo_empty, fifo_pop, push_req, push_ok, wr_en, bit_end;
  logic [7:0]  fifo_dat;
  logic        unused_bits;

  assign unused_bits = ^{wdata[31:16], addr[1:0]};

  assign wr_en    = sel & we;
  assign push_req = wr_en && (addr[3:2] == REG_TXDATA);
  // A pop on the same edge frees a slot, so a write to a full FIFO still lands.
  assign push_ok  = push_req && (!fifo_full || fifo_pop);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (push_ok),
    .push_dat (wdata[7:0]),
    .pop_vld  (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    ovf_d = ovf_q;
    div_d = div_q;
    if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end else if (wr_en && (addr[3:2] == REG_STATUS) && wdata[STAT_OVF]) begin
      ovf_d = 1'b0;
    end
    if (wr_en && (addr[3:2] == REG_DIV)) begin
      div_d = div_sanitize(wdata[15:0]);
    end
  end

  // bit_div_q holds the compare for the bit in flight, so DIV writes wait for a bit boundary.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    bit_div_d = bit_div_q;
    fifo_pop  = 1'b0;
    tx_d      = 1'b1;
`ifdef UART_PARITY_EN
    par_d     = par_q;
`endif
    bit_end   = (timer_q == (bit_div_q - 16'd1));

    if (state_q != ST_IDLE) begin
      if (bit_end) begin
        timer_d   = '0;
        bit_div_d = div_q;
      end else begin
        timer_d   = timer_q + 16'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_dat;
          timer_d   = '0;
          bit_div_d = div_q;
          state_d   = ST_START;
`ifdef UART_PARITY_EN
          par_d     = ^fifo_dat;
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // tx is registered from the next state so the pin is glitch-free.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
`ifdef UART_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      div_q     <= DIV_RESET;
      bit_div_q <= DIV_RESET;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      ovf_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_div_q <= bit_div_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      ovf_q     <= ovf_d;
      tx_q      <= tx_d;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    case (addr[3:2])
      REG_STATUS: begin
        rdata[STAT_BUSY]  = (state_q != ST_IDLE);
        rdata[STAT_FULL]  = fifo_full;
        rdata[STAT_EMPTY] = fifo_empty;
        rdata[STAT_OVF]   = ovf_q;
        rdata[STAT_PAR]   = PARITY_PRESENT;
      end
      REG_DIV: rdata[15:0] = div_q;
      default: rdata = '0;
    endcase
  end

  assign tx        = tx_q;
  assign irq_empty = fifo_empty && (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: hand-computed tx waveforms, STATUS/DIV values and reset behaviour.
module tb_uart_tx_mmio;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;
  logic        irq_empty;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] rd;
  logic [7:0]  byte_v;
  logic        exp_bit;
  bit          found;

`ifdef UART_PARITY_EN
  localparam logic [31:0] PAR = 32'h10;
`else
  localparam logic [31:0] PAR = 32'h0;
`endif

  always #5 clk = ~clk;

  uart_tx_mmio #(
    .FIFO_DEPTH (4),
    .DIV_RESET  (16'd434)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .tx        (tx),
    .irq_empty (irq_empty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    sel = 1'b0; we = 1'b0; addr = 4'h4; wdata = '0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a;
    #1;
    d = rdata;
  endtask

  initial begin
    reset = 1'b0; sel = 1'b0; we = 1'b0; addr = 4'h4; wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tx", {31'b0, tx}, 32'h1);
    check("rst_irq", {31'b0, irq_empty}, 32'h1);
    check("rst_status", rdata, 32'h4 | PAR);
    @(negedge clk);
    reset = 1'b1;
    bus_read(4'h8, rd);   check("rst_div", rd, 32'd434);
    bus_read(4'h0, rd);   check("txdata_reads0", rd, 32'h0);
    bus_read(4'hC, rd);   check("reg_c_reads0", rd, 32'h0);
    bus_write(4'hC, 32'hFFFF_FFFF);
    bus_read(4'h4, rd);   check("reg_c_wr_status", rd, 32'h4 | PAR);
    bus_read(4'h8, rd);   check("reg_c_wr_div", rd, 32'd434);

    // Test 1: DIV=4, single 0x55 frame
    bus_write(4'h8, 32'd4);
    bus_read(4'h8, rd);   check("div4", rd, 32'd4);
    byte_v = 8'h55;
    bus_write(4'h0, {24'b0, byte_v});
    @(negedge clk);
    check("t1_cyc0_idle", {31'b0, tx}, 32'h1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k <= 4)       exp_bit = 1'b0;
      else if (k <= 36) exp_bit = byte_v[(k - 5) / 4];
      else              exp_bit = 1'b1;
      check($sformatf("t1_tx_c%0d", k), {31'b0, tx}, {31'b0, exp_bit});
      if (k == 40) check("t1_busy_c40", rdata, 32'h5 | PAR);
    end
    @(negedge clk);
    check("t1_status_done", rdata, 32'h4 | PAR);
    check("t1_irq_done", {31'b0, irq_empty}, 32'h1);

    // Test 2: six back-to-back writes into a 4-deep FIFO
    for (int i = 0; i < 6; i++) bus_write(4'h0, 32'h11 + i);
    bus_read(4'h4, rd);   check("t2_status_ovf", rd, 32'hB | PAR);
    bus_write(4'h4, 32'h8);
    bus_read(4'h4, rd);   check("t2_status_w1c", rd, 32'h3 | PAR);

    // Test 3: write to full FIFO in the cycle IDLE pops
    found = 1'b0;
    addr = 4'h4;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (rdata[0] == 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check("t3_idle_seen", {31'b0, found}, 32'h1);
    sel = 1'b1; we = 1'b1; addr = 4'h0; wdata = 32'h77;
    @(posedge clk);
    #1;
    sel = 1'b0; we = 1'b0; addr = 4'h4; wdata = '0;
    @(negedge clk);
    check("t3_status", rdata, 32'h3 | PAR);

    found = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (irq_empty) begin
        found = 1'b1;
        break;
      end
    end
    check("t3_drained", {31'b0, found}, 32'h1);
    check("t3_drain_status", rdata, 32'h4 | PAR);

    // Test 4: async reset during DATA bit 3 (0xF7 has bit3 = 0)
    bus_write(4'h0, 32'hF7);
    @(negedge clk);
    for (int k = 1; k <= 18; k++) @(negedge clk);
    check("t4_bit3_low", {31'b0, tx}, 32'h0);
    reset = 1'b0;
    #1;
    check("t4_tx_async", {31'b0, tx}, 32'h1);
    check("t4_status_in_rst", rdata, 32'h4 | PAR);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bus_read(4'h4, rd);   check("t4_status_after", rd, 32'h4 | PAR);
    bus_read(4'h8, rd);   check("t4_div_after", rd, 32'd434);
    check("t4_irq_after", {31'b0, irq_empty}, 32'h1);

    // Test 5: DIV=0 stored as 1, 0xFF frame is 10 cycles
    bus_write(4'h8, 32'd0);
    bus_read(4'h8, rd);   check("t5_div_read", rd, 32'd1);
    bus_write(4'h0, 32'hFF);
    @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1)  check("t5_start", {31'b0, tx}, 32'h0);
      if (k == 9)  check("t5_d7", {31'b0, tx}, 32'h1);
      if (k == 10) check("t5_busy_c10", {31'b0, rdata[0]}, 32'h1);
      if (k == 11) check("t5_idle_c11", {31'b0, rdata[0]}, 32'h0);
    end
    check("t5_irq", {31'b0, irq_empty}, 32'h1);

    // Test 6: parity flag; with parity, DIV=2 and 0x07 gives an 11-bit frame
    bus_read(4'h4, rd);   check("t6_par_flag", {31'b0, rd[4]}, PAR >> 4);
`ifdef UART_PARITY_EN
    bus_write(4'h8, 32'd2);
    bus_write(4'h0, 32'h07);
    @(negedge clk);
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      if (k == 17) check("t6_d7", {31'b0, tx}, 32'h0);
      if (k == 19) check("t6_par_a", {31'b0, tx}, 32'h1);
      if (k == 20) check("t6_par_b", {31'b0, tx}, 32'h1);
      if (k == 21) check("t6_stop", {31'b0, tx}, 32'h1);
      if (k == 22) check("t6_busy_c22", {31'b0, rdata[0]}, 32'h1);
      if (k == 23) check("t6_idle_c23", {31'b0, rdata[0]}, 32'h0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
